// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DBG  = 2'd2
  } grant_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - saturating up-counter with clear, used for debug starvation
module arb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over increment so a handshake always restarts the count.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < limit_i)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data memory between the core load/store path and a debug port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_memwrite,
  input  logic          cpu_memread,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_valid,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ready,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          halt_req,
  output logic          halt_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q;
  logic [CNT_W-1:0] starve_cnt;
  logic             halt_ack_q;
  logic             rvalid_q;
  logic [DW-1:0]    rdata_q;
  logic [DW-1:0]    rdata_d;

  logic             in_reset;
  arb_state_t       eff_state;
  logic [CNT_W-1:0] eff_cnt;
  logic             cpu_req;
  grant_t           grant;
  logic             dbg_hs;
  logic             rd_hs;
  logic             cnt_inc;

  // While reset is held the combinational path behaves as RUN with an empty count.
  assign in_reset  = !reset;
  assign eff_state = in_reset ? RUN : state_q;
  assign eff_cnt   = in_reset ? '0 : starve_cnt;
  assign cpu_req   = cpu_memwrite | cpu_memread;

  always_comb begin
    grant = GNT_NONE;
    if (eff_state == HALTED) begin
      if (dbg_valid) grant = GNT_DBG;
    end else if (dbg_valid && (!cpu_req || (eff_cnt == LIMIT))) begin
      grant = GNT_DBG;
    end else if (cpu_req) begin
      grant = GNT_CPU;
    end
  end

  assign dbg_hs    = (grant == GNT_DBG);
  assign rd_hs     = dbg_hs & !dbg_we;
  assign dbg_ready = dbg_hs;
  assign cpu_stall = (cpu_req & dbg_hs) | (eff_state == HALTED);
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (grant)
      GNT_DBG: begin
        mem_we    = dbg_valid & dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      GNT_CPU: begin
        mem_we = cpu_memwrite & !cpu_stall;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Refusals are only counted in RUN; in HALTED every pending request is granted.
  assign cnt_inc = (eff_state == RUN) & dbg_valid & !dbg_hs;

  arb_sat_counter #(
    .W(CNT_W)
  ) u_starve_cnt (
    .clk_i   (clk),
    .resetn_i(reset),
    .inc_i   (cnt_inc),
    .clr_i   (dbg_hs),
    .limit_i (LIMIT),
    .count_o (starve_cnt)
  );

  assign rdata_d = rd_hs ? mem_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      halt_ack_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (halt_req) state_q <= HALTED;
        end
        HALTED: begin
          if (!halt_req) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
      halt_ack_q <= halt_req;
      rvalid_q   <= rd_hs;
      rdata_q    <= rdata_d;
    end
  end

  assign halt_ack   = halt_ack_q;
  assign dbg_rvalid = rvalid_q;
  assign dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural model
module tb_dmem_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memwrite, cpu_memread;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_valid, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ready, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        halt_req, halt_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [64];
  logic [31:0] shadow [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .halt_req(halt_req), .halt_ack(halt_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'd63);
  endfunction

  assign mem_rdata = mem[widx(mem_addr)];

  always @(posedge clk) begin
    if (mem_we) mem[widx(mem_addr)] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model state: registered halt, refusals since last acceptance, pending read return.
  bit          m_halt = 0;
  int          m_refused = 0;
  bit          m_rv = 0;
  logic [31:0] m_rd = '0;

  initial begin : compare
    bit rst, halted, creq, ok, stall, e_we;
    int refused;
    logic [31:0] e_addr, e_wdata;
    @(posedge clk);
    forever begin
      @(negedge clk);
      rst     = !reset;
      halted  = !rst && m_halt;
      refused = rst ? 0 : m_refused;
      creq    = cpu_memwrite || cpu_memread;
      ok      = dbg_valid && (halted || !creq || refused >= LIMIT);
      stall   = halted || (creq && ok);
      e_we    = ok ? dbg_we : (cpu_memwrite && !stall);
      e_addr  = ok ? dbg_addr : cpu_addr;
      e_wdata = ok ? dbg_wdata : cpu_wdata;
      chk("m_dbg_ready", dbg_ready, ok);
      chk("m_cpu_stall", cpu_stall, stall);
      chk("m_mem_we", mem_we, e_we);
      chk("m_mem_addr", mem_addr, e_addr);
      if (e_we) chk("m_mem_wdata", mem_wdata, e_wdata);
      chk("m_cpu_rdata", cpu_rdata, shadow[widx(e_addr)]);
      chk("m_halt_ack", halt_ack, m_halt);
      chk("m_dbg_rvalid", dbg_rvalid, m_rv);
      if (m_rv) chk("m_dbg_rdata", dbg_rdata, m_rd);
      if (rst) begin
        m_halt = 0; m_refused = 0; m_rv = 0; m_rd = '0;
      end else begin
        m_halt = halt_req;
        if (ok) begin
          m_refused = 0;
          m_rv = !dbg_we;
          if (!dbg_we) m_rd = shadow[widx(dbg_addr)];
        end else begin
          m_rv = 0;
          if (dbg_valid && m_refused < LIMIT) m_refused++;
        end
      end
      if (e_we) shadow[widx(e_addr)] = e_wdata;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : driver
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    reset = 1'b0; halt_req = 1'b0;
    cpu_memwrite = 1'b0; cpu_memread = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40; dbg_wdata = '0;

    // Reset with a debug read pending
    repeat (3) tick();
    #1;
    chk("rst_rvalid", dbg_rvalid, 1'b0);
    chk("rst_halt_ack", halt_ack, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", dbg_ready, 1'b1);
    tick();
    dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'hDEADBEEF;
    #1;
    chk("post_rst_rvalid", dbg_rvalid, 1'b1);
    chk("post_rst_rdata", dbg_rdata, 32'h0);

    // Idle-core write then read
    chk("idle_wr_ready", dbg_ready, 1'b1);
    chk("idle_wr_stall", cpu_stall, 1'b0);
    tick();
    dbg_we = 1'b0;
    #1;
    chk("idle_rd_ready", dbg_ready, 1'b1);
    chk("idle_wr_rvalid", dbg_rvalid, 1'b0);
    tick();
    dbg_valid = 1'b0;
    #1;
    chk("idle_rd_rvalid", dbg_rvalid, 1'b1);
    chk("idle_rd_rdata", dbg_rdata, 32'hDEADBEEF);

    // Starvation: core loads every cycle
    tick();
    cpu_memread = 1'b1; cpu_addr = 32'h40;
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    #1;
    n = 1;
    while (!dbg_ready && n < 20) begin
      tick(); #1; n++;
    end
    chk("starve_cycles", n, 9);
    chk("starve_stall", cpu_stall, 1'b1);
    tick();
    dbg_valid = 1'b0; cpu_memread = 1'b0;

    // Contention on address 16
    tick();
    cpu_memwrite = 1'b1; cpu_addr = 32'd16; cpu_wdata = 32'hFFFFFFFA;
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd16; dbg_wdata = 32'd5;
    #1;
    chk("cont_ready0", dbg_ready, 1'b0);
    tick(); #1;
    chk("cont_mem_cpu", mem[4], 32'hFFFFFFFA);
    n = 2;
    while (!dbg_ready && n < 20) begin
      tick(); #1; n++;
    end
    chk("cont_cycles", n, 9);
    chk("cont_stall", cpu_stall, 1'b1);
    tick();
    dbg_valid = 1'b0;
    #1;
    chk("cont_mem_dbg", mem[4], 32'd5);
    chk("cont_replay_we", mem_we, 1'b1);
    tick();
    cpu_memwrite = 1'b0;
    #1;
    chk("cont_mem_replay", mem[4], 32'hFFFFFFFA);

    // Halt for 10 cycles with debug writes every cycle
    for (int k = 1; k <= 12; k++) begin
      tick();
      halt_req = (k <= 10);
      dbg_valid = (k <= 11); dbg_we = 1'b1;
      dbg_addr = 32'h80 + 32'(4 * k); dbg_wdata = 32'(k);
      cpu_memwrite = (k % 2 == 0); cpu_addr = 32'h20; cpu_wdata = 32'h1234;
      #1;
      chk("halt_ack_cyc", halt_ack, (k >= 2 && k <= 11));
      if (k >= 2 && k <= 11) begin
        chk("halt_stall", cpu_stall, 1'b1);
        chk("halt_ready", dbg_ready, 1'b1);
      end
      if (k == 12) chk("halt_no_cpu_wr", mem[8], 32'h0);
    end
    tick();
    cpu_memwrite = 1'b0;
    #1;
    chk("halt_cpu_after", mem[8], 32'h1234);
    chk("halt_dbg_wr", mem[widx(32'h94)], 32'd5);

    // Reset on the edge of a debug read handshake
    tick();
    reset = 1'b0;
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    #1;
    chk("rstrd_ready", dbg_ready, 1'b1);
    tick();
    reset = 1'b1; dbg_valid = 1'b0;
    #1;
    chk("rstrd_rvalid", dbg_rvalid, 1'b0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
